mem_bus_bridge: RTL and testbench
=================================

# mem_bus_bridge

Sits directly downstream of the `cpu` core, between its SRAM-style instruction and data ports and a single shared memory bus with request/grant/response handshake. Captures one instruction fetch and one data access per CPU cycle and serialises them onto the bus, data first. It drives a stall back to the core until every captured access has completed. Exactly one bus transaction is outstanding at any time.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_en`  in  1  instruction fetch request.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_rdata`  out  DATA_W  registered fetch data.
- `inst_rvalid`  out  1  one-cycle pulse: `inst_rdata` is new.
- `data_en`  in  1  data access request.
- `data_wen`  in  DATA_W/8  byte write strobes; 0 = read.
- `data_addr`  in  ADDR_W  data address.
- `data_wdata`  in  DATA_W  store data.
- `data_rdata`  out  DATA_W  registered load data.
- `data_rvalid`  out  1  one-cycle pulse on completion (load or store).
- `cpu_stall`  out  1  core must hold all pipeline registers and requests.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  write transaction.
- `bus_wstrb`  out  DATA_W/8  byte strobes.
- `bus_addr`  out  ADDR_W  transaction address.
- `bus_wdata`  out  DATA_W  write data.
- `bus_gnt`  in  1  address phase accepted this cycle.
- `bus_rvalid`  in  1  response (read data or write ack) this cycle.
- `bus_rdata`  in  DATA_W  read data, valid with `bus_rvalid`.

## Operation
States:
- IDLE
- D_REQ: data request on bus.
- D_WAIT: data response pending.
- I_REQ: fetch request on bus.
- I_WAIT: fetch response pending.

Capture:
- Capture happens in IDLE when `cpu_stall`=0 and (`inst_en`|`data_en`).
- On capture, latch address, strobes and wdata into holding registers, and set `inst_pend`/`data_pend`.

Transitions:
- IDLE→D_REQ if data captured, else →I_REQ.
- x_REQ→x_WAIT on `bus_gnt`.
- D_WAIT→I_REQ on `bus_rvalid` if `inst_pend`, else →IDLE.
- I_WAIT→IDLE on `bus_rvalid`.

Bus outputs:
- `bus_req` is 1 only in D_REQ and I_REQ.
- `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` come from the holding registers and stay stable while `bus_req` is 1.
- In I_REQ, `bus_we`=0 and `bus_wstrb`=0.
- `bus_we` = |`data_wen` (latched).

Responses:
- On `bus_rvalid` in x_WAIT, load `bus_rdata` into `x_rdata`, clear `x_pend`, and pulse `x_rvalid` next cycle.
- Stores leave `data_rdata` unchanged but still pulse `data_rvalid`.
- `cpu_stall` = `inst_pend` | `data_pend`, combinational from registers.
- `cpu_stall` is high from the cycle after capture until the cycle after the last response; it is low in the cycle its `x_rvalid` is high.

Boundary behaviour:
- `bus_gnt` is ignored outside x_REQ.
- `bus_rvalid` is ignored outside x_WAIT; stray responses are not a fault.
- `bus_gnt` and `bus_rvalid` in the same cycle while in x_REQ: take only the grant. The bus must not respond in the grant cycle.
- `x_rdata` holds its last value indefinitely.

## Timing
Reset values (all outputs 0, asserted asynchronously):
- state IDLE.
- `inst_pend` and `data_pend` cleared.
- holding registers 0.

Reset mid-transaction:
- Abandon the transaction and return to IDLE.
- Any later `bus_rvalid` lands in IDLE and is ignored.

Latency and throughput:
- Minimum single-access latency, capture edge to `x_rvalid`, is 3 cycles with `bus_gnt` in the first REQ cycle and `bus_rvalid` the cycle after the grant.
- Dual access: fetch starts the cycle after the data response, so minimum 5 cycles.
- Back-to-back captures are possible: capture may occur in the same cycle that `x_rvalid` is high.

## Structure
- A shared package or defines header holds:
  - the state encoding (3-bit constants `BR_IDLE`, `BR_D_REQ`, `BR_D_WAIT`, `BR_I_REQ`, `BR_I_WAIT`);
  - `WORD_WIDTH` reuse.
- One natural sub-module is `bus_req_hold`: a holding register with load, parameterised by width, instantiated for the instruction and data paths.
- The FSM stays in the top.

## Test plan
- Fetch only: `inst_en`=1, `inst_addr`=0x1000; bus grants immediately and returns 0x24020005 one cycle later → `bus_addr`=0x1000 with `bus_we`=0; `inst_rdata`=0x24020005 with `inst_rvalid` pulse 3 cycles after capture; `cpu_stall` high 2 cycles.
- Simultaneous load and fetch: `data_addr`=0x2000 (read), `inst_addr`=0x1004 → bus order is 0x2000 then 0x1004; `data_rvalid` precedes `inst_rvalid`; `cpu_stall` drops only after the fetch completes.
- Byte store: `data_wen`=4'b0001, `data_wdata`=0xAABBCCDD, `bus_gnt` delayed 4 cycles → `bus_req`, `bus_addr`, `bus_wdata` and `bus_wstrb`=0001 held stable for 5 cycles; `data_rdata` unchanged; `data_rvalid` pulses.
- Reset during D_WAIT, then `bus_rvalid` with 0xDEADBEEF → all outputs 0, state IDLE, `data_rdata` stays 0.
- Stray `bus_rvalid` in IDLE and same-cycle `bus_gnt`+`bus_rvalid` in D_REQ → no rvalid pulse, no state skip to IDLE.
- Back-to-back fetches 0x1000, 0x1004, 0x1008 with one-cycle bus → three `inst_rvalid` pulses with correct data; the new capture occurs in the same cycle each pulse is high.

Source files
------------

// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
// State encoding and word-size defaults live here.
package mem_bus_bridge_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    BR_IDLE   = 3'd0,
    BR_D_REQ  = 3'd1,
    BR_D_WAIT = 3'd2,
    BR_I_REQ  = 3'd3,
    BR_I_WAIT = 3'd4
  } brState_t;

  function automatic logic isReqState(brState_t s);
    return (s == BR_D_REQ) || (s == BR_I_REQ);
  endfunction

  function automatic logic isDataState(brState_t s);
    return (s == BR_D_REQ) || (s == BR_D_WAIT);
  endfunction

endpackage

// File: rtl/mem_bus_bridge_hold.sv
// Width-parameterised holding register with synchronous load.
// Cleared by the asynchronous reset, otherwise holds indefinitely.
module bus_req_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // capture d on load, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Serialises one data access and one fetch per CPU cycle onto
// a single request/grant/response bus, data first.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = WORD_WIDTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_rvalid,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_rvalid,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DHOLD_W = ADDR_W + STRB_W + DATA_W;

  brState_t state;
  logic instPend;
  logic dataPend;
  logic instRvalid;
  logic dataRvalid;

  logic capture;
  logic instLoad;
  logic dataLoad;
  logic instRdLoad;
  logic dataRdLoad;

  logic [ADDR_W-1:0]  iAddr;
  logic [DHOLD_W-1:0] dataHold;
  logic [ADDR_W-1:0]  dAddr;
  logic [STRB_W-1:0]  dWen;
  logic [DATA_W-1:0]  dWdata;
  logic               dIsWrite;

  assign cpu_stall = instPend | dataPend;
  assign capture = (state == BR_IDLE) && !cpu_stall
                   && (inst_en || data_en);
  assign instLoad = capture && inst_en;
  assign dataLoad = capture && data_en;

  assign {dAddr, dWen, dWdata} = dataHold;
  assign dIsWrite = |dWen;

  assign instRdLoad = (state == BR_I_WAIT) && bus_rvalid;
  assign dataRdLoad = (state == BR_D_WAIT) && bus_rvalid
                      && !dIsWrite;

  bus_req_hold #(.W(ADDR_W)) uInstHold (
    .clk   (clk),
    .rst_n (resetn),
    .load  (instLoad),
    .d     (inst_addr),
    .q     (iAddr)
  );

  bus_req_hold #(.W(DHOLD_W)) uDataHold (
    .clk   (clk),
    .rst_n (resetn),
    .load  (dataLoad),
    .d     ({data_addr, data_wen, data_wdata}),
    .q     (dataHold)
  );

  bus_req_hold #(.W(DATA_W)) uInstRdata (
    .clk   (clk),
    .rst_n (resetn),
    .load  (instRdLoad),
    .d     (bus_rdata),
    .q     (inst_rdata)
  );

  bus_req_hold #(.W(DATA_W)) uDataRdata (
    .clk   (clk),
    .rst_n (resetn),
    .load  (dataRdLoad),
    .d     (bus_rdata),
    .q     (data_rdata)
  );

  // sequencer: one outstanding transaction, data before fetch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= BR_IDLE;
      instPend   <= 1'b0;
      dataPend   <= 1'b0;
      instRvalid <= 1'b0;
      dataRvalid <= 1'b0;
    end else begin
      instRvalid <= 1'b0;
      dataRvalid <= 1'b0;
      unique case (state)
        BR_IDLE: begin
          if (capture) begin
            instPend <= inst_en;
            dataPend <= data_en;
            state    <= data_en ? BR_D_REQ : BR_I_REQ;
          end
        end
        BR_D_REQ: begin
          if (bus_gnt) state <= BR_D_WAIT;
        end
        BR_D_WAIT: begin
          if (bus_rvalid) begin
            dataPend   <= 1'b0;
            dataRvalid <= 1'b1;
            state      <= instPend ? BR_I_REQ : BR_IDLE;
          end
        end
        BR_I_REQ: begin
          if (bus_gnt) state <= BR_I_WAIT;
        end
        BR_I_WAIT: begin
          if (bus_rvalid) begin
            instPend   <= 1'b0;
            instRvalid <= 1'b1;
            state      <= BR_IDLE;
          end
        end
        default: state <= BR_IDLE;
      endcase
    end
  end

  assign inst_rvalid = instRvalid;
  assign data_rvalid = dataRvalid;

  // bus fields come from whichever holding register owns the bus
  always_comb begin
    bus_req   = isReqState(state);
    bus_addr  = iAddr;
    bus_we    = 1'b0;
    bus_wstrb = '0;
    bus_wdata = '0;
    if (isDataState(state)) begin
      bus_addr  = dAddr;
      bus_we    = dIsWrite;
      bus_wstrb = dWen;
      bus_wdata = dWdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge with a queue-based
// reference model checked every cycle.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int vectors = 0;
  int errs = 0;

  mem_bus_bridge dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_en     (inst_en),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_rvalid (inst_rvalid),
    .data_en     (data_en),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_rvalid (data_rvalid),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_wstrb   (bus_wstrb),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: pending accesses as a FIFO, head may be granted
  typedef struct {
    bit          isData;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } acc_t;

  acc_t        mq[$];
  bit          mGranted = 0;
  logic        mIv = 0;
  logic        mDv = 0;
  logic [31:0] mIr = '0;
  logic [31:0] mDr = '0;

  always @(posedge clk or negedge resetn) begin
    acc_t h;
    if (!resetn) begin
      mq.delete();
      mGranted = 0;
      mIv = 0;
      mDv = 0;
      mIr = '0;
      mDr = '0;
    end else begin
      mIv = 0;
      mDv = 0;
      if (mq.size() > 0) begin
        if (!mGranted) begin
          if (bus_gnt) mGranted = 1;
        end else if (bus_rvalid) begin
          h = mq.pop_front();
          mGranted = 0;
          if (h.isData) begin
            mDv = 1;
            if (!h.we) mDr = bus_rdata;
          end else begin
            mIv = 1;
            mIr = bus_rdata;
          end
        end
      end else if (inst_en || data_en) begin
        if (data_en) begin
          h.isData = 1;
          h.addr = data_addr;
          h.we = |data_wen;
          h.strb = data_wen;
          h.wdata = data_wdata;
          mq.push_back(h);
        end
        if (inst_en) begin
          h.isData = 0;
          h.addr = inst_addr;
          h.we = 0;
          h.strb = '0;
          h.wdata = '0;
          mq.push_back(h);
        end
      end
    end
  end

  // compare DUT to model on every falling edge
  always @(negedge clk) begin
    logic expReq;
    expReq = (mq.size() > 0) && !mGranted;
    check("stall", 32'(cpu_stall), 32'(mq.size() > 0));
    check("bus_req", 32'(bus_req), 32'(expReq));
    check("inst_rvalid", 32'(inst_rvalid), 32'(mIv));
    check("data_rvalid", 32'(data_rvalid), 32'(mDv));
    check("inst_rdata", inst_rdata, mIr);
    check("data_rdata", data_rdata, mDr);
    if (expReq) begin
      check("bus_addr", bus_addr, mq[0].addr);
      check("bus_we", 32'(bus_we), 32'(mq[0].we));
      check("bus_wstrb", 32'(bus_wstrb), 32'(mq[0].strb));
      if (mq[0].isData)
        check("bus_wdata", bus_wdata, mq[0].wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // grant after gd idle cycles, respond the cycle after grant
  task automatic serve(input int gd, input logic [31:0] rd);
    int n;
    n = 0;
    while (!bus_req && n < 20) begin
      step();
      n++;
    end
    if (!bus_req) begin
      check("req_timeout", 32'(bus_req), 32'd1);
    end else begin
      for (int i = 0; i < gd; i++) step();
      bus_gnt = 1;
      step();
      bus_gnt = 0;
      bus_rvalid = 1;
      bus_rdata = rd;
      step();
      bus_rvalid = 0;
    end
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h1008;
    words[0] = 32'hA0A0_0001;
    words[1] = 32'hB0B0_0002;
    words[2] = 32'hC0C0_0003;

    #1;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    step();
    step();
    resetn = 1;
    step();

    // fetch only
    inst_en = 1; inst_addr = 32'h1000;
    step();
    inst_en = 0;
    check("f_req", 32'(bus_req), 32'd1);
    check("f_addr", bus_addr, 32'h1000);
    check("f_we", 32'(bus_we), 32'd0);
    check("f_stall1", 32'(cpu_stall), 32'd1);
    bus_gnt = 1;
    step();
    bus_gnt = 0;
    check("f_stall2", 32'(cpu_stall), 32'd1);
    check("f_req_wait", 32'(bus_req), 32'd0);
    bus_rvalid = 1; bus_rdata = 32'h2402_0005;
    step();
    bus_rvalid = 0;
    check("f_rvalid", 32'(inst_rvalid), 32'd1);
    check("f_rdata", inst_rdata, 32'h2402_0005);
    check("f_stall3", 32'(cpu_stall), 32'd0);
    step();
    check("f_pulse_end", 32'(inst_rvalid), 32'd0);

    // simultaneous load and fetch
    data_en = 1; data_wen = 4'b0000; data_addr = 32'h2000;
    inst_en = 1; inst_addr = 32'h1004;
    step();
    data_en = 0; inst_en = 0;
    check("lf_addr0", bus_addr, 32'h2000);
    check("lf_we0", 32'(bus_we), 32'd0);
    serve(0, 32'h1111_1111);
    check("lf_drv", 32'(data_rvalid), 32'd1);
    check("lf_irv0", 32'(inst_rvalid), 32'd0);
    check("lf_drd", data_rdata, 32'h1111_1111);
    check("lf_stall", 32'(cpu_stall), 32'd1);
    check("lf_addr1", bus_addr, 32'h1004);
    serve(0, 32'h2222_2222);
    check("lf_irv", 32'(inst_rvalid), 32'd1);
    check("lf_ird", inst_rdata, 32'h2222_2222);
    check("lf_stall_end", 32'(cpu_stall), 32'd0);
    step();

    // byte store with delayed grant
    data_en = 1; data_wen = 4'b0001; data_addr = 32'h3000;
    data_wdata = 32'hAABB_CCDD;
    step();
    data_en = 0; data_wen = '0; data_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      check("st_req", 32'(bus_req), 32'd1);
      check("st_addr", bus_addr, 32'h3000);
      check("st_wdata", bus_wdata, 32'hAABB_CCDD);
      check("st_wstrb", 32'(bus_wstrb), 32'h1);
      check("st_we", 32'(bus_we), 32'd1);
      bus_gnt = (i == 4);
      step();
    end
    bus_gnt = 0;
    bus_rvalid = 1; bus_rdata = 32'h5555_5555;
    step();
    bus_rvalid = 0;
    check("st_rvalid", 32'(data_rvalid), 32'd1);
    check("st_rdata", data_rdata, 32'h1111_1111);
    step();

    // reset during D_WAIT, late response ignored
    data_en = 1; data_addr = 32'h4000;
    step();
    data_en = 0;
    bus_gnt = 1;
    step();
    bus_gnt = 0;
    resetn = 0;
    #1;
    check("rr_req", 32'(bus_req), 32'd0);
    check("rr_stall", 32'(cpu_stall), 32'd0);
    check("rr_addr", bus_addr, 32'd0);
    check("rr_drd", data_rdata, 32'd0);
    check("rr_ird", inst_rdata, 32'd0);
    step();
    resetn = 1;
    bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_rvalid = 0;
    check("rr_drv", 32'(data_rvalid), 32'd0);
    check("rr_drd2", data_rdata, 32'd0);
    check("rr_stall2", 32'(cpu_stall), 32'd0);
    step();

    // stray response in IDLE, then grant+rvalid together
    bus_rvalid = 1; bus_rdata = 32'h7777_7777;
    step();
    bus_rvalid = 0;
    check("sr_drv", 32'(data_rvalid), 32'd0);
    check("sr_irv", 32'(inst_rvalid), 32'd0);
    data_en = 1; data_addr = 32'h5000;
    step();
    data_en = 0;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h8888_8888;
    step();
    bus_gnt = 0; bus_rvalid = 0;
    check("gr_drv", 32'(data_rvalid), 32'd0);
    check("gr_stall", 32'(cpu_stall), 32'd1);
    check("gr_req", 32'(bus_req), 32'd0);
    bus_rvalid = 1; bus_rdata = 32'h9999_9999;
    step();
    bus_rvalid = 0;
    check("gr_drv2", 32'(data_rvalid), 32'd1);
    check("gr_drd", data_rdata, 32'h9999_9999);
    step();

    // back-to-back fetches, recapture in the pulse cycle
    inst_en = 1; inst_addr = addrs[0];
    for (int k = 0; k < 3; k++) begin
      step();
      inst_en = 0;
      check("bb_addr", bus_addr, addrs[k]);
      bus_gnt = 1;
      step();
      bus_gnt = 0;
      bus_rvalid = 1; bus_rdata = words[k];
      step();
      bus_rvalid = 0;
      check("bb_rvalid", 32'(inst_rvalid), 32'd1);
      check("bb_rdata", inst_rdata, words[k]);
      check("bb_stall", 32'(cpu_stall), 32'd0);
      if (k < 2) begin
        inst_en = 1; inst_addr = addrs[k+1];
      end
    end
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
